// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, decode redirects, CP0
// exception/ERET redirects, and a one-entry buffer for redirects seen during a stall.
module pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h00003000,
    parameter logic [31:0] EXC_VECTOR = 32'h00004180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc32,
    output logic [31:0] pc4,
    output logic        redirect_pending
);

    logic [31:0] pc_r;
    logic        pend_valid_r;
    logic [31:0] pend_target_r;

    logic [31:0] pc_next_s;
    logic        pend_valid_next_s;
    logic [31:0] pend_target_next_s;

    // Next-state selection; exceptions and ERET override stall, live redirect beats buffered one
    always_comb begin
        pc_next_s          = pc_r;
        pend_valid_next_s  = pend_valid_r;
        pend_target_next_s = pend_target_r;
        if (exc_req) begin
            pc_next_s         = EXC_VECTOR;
            pend_valid_next_s = 1'b0;
        end else if (eret) begin
            pc_next_s         = epc;
            pend_valid_next_s = 1'b0;
        end else if (stall) begin
            if (redirect) begin
                pend_target_next_s = redirect_target;
                pend_valid_next_s  = 1'b1;
            end else begin
                pend_target_next_s = pend_target_r;
                pend_valid_next_s  = pend_valid_r;
            end
        end else begin
            pend_valid_next_s = 1'b0;
            if (redirect) begin
                pc_next_s = redirect_target;
            end else if (pend_valid_r) begin
                pc_next_s = pend_target_r;
            end else begin
                pc_next_s = pc_r + 32'd4;
            end
        end
    end

    // State registers with synchronous reset; reset also discards any buffered target
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h00000000;
        end else begin
            pc_r          <= pc_next_s;
            pend_valid_r  <= pend_valid_next_s;
            pend_target_r <= pend_target_next_s;
        end
    end

    assign pc32             = pc_r;
    assign pc4              = pc_r + 32'd4;
    assign redirect_pending = pend_valid_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h00003000;
    localparam logic [31:0] EXC_PC = 32'h00004180;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, exc_req, eret;
    logic [31:0] redirect_target, epc;
    logic [31:0] pc32, pc4;
    logic        redirect_pending;

    int checks = 0;
    int errors = 0;

    // Reference model: current PC plus every redirect seen while stalled (the last one counts)
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .exc_req(exc_req), .eret(eret),
        .epc(epc), .pc32(pc32), .pc4(pc4), .redirect_pending(redirect_pending)
    );

    task automatic clear_inputs();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; exc_req = 1'b0; eret = 1'b0;
        redirect_target = 32'h0; epc = 32'h0;
    endtask

    // Advance the model by the priority rules, then clock the DUT and settle
    task automatic tick();
        if (reset) begin
            m_pc = RST_PC; m_pend.delete();
        end else if (exc_req) begin
            m_pc = EXC_PC; m_pend.delete();
        end else if (eret) begin
            m_pc = epc; m_pend.delete();
        end else if (stall) begin
            if (redirect) m_pend.push_back(redirect_target);
        end else begin
            if (redirect) m_pc = redirect_target;
            else if (m_pend.size() > 0) m_pc = m_pend[$];
            else m_pc = m_pc + 32'd4;
            m_pend.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
        clear_inputs();
        reset = 1'b1;
        tick();
        checks++;
        if (pc4 !== 32'h3004 || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc4=%h pend=%b required pc4=00003004 pend=0", pc4, redirect_pending);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (pc32 !== exp_seq[i]) begin
                errors++;
                $display("FAIL seq_run[%0d] pc32=%h required %h", i, pc32, exp_seq[i]);
            end
            if (i == 2) begin
                checks++;
                if (pc4 !== 32'h300C) begin
                    errors++;
                    $display("FAIL seq_pc4 pc4=%h required 0000300c", pc4);
                end
            end
        end
    endtask

    task automatic test_redirect();
        clear_inputs();
        tick();
        checks++;
        if (pc32 !== 32'h3010) begin
            errors++;
            $display("FAIL redir_setup pc32=%h required 00003010", pc32);
        end
        redirect = 1'b1; redirect_target = 32'h3100;
        tick();
        checks++;
        if (pc32 !== 32'h3100) begin
            errors++;
            $display("FAIL redir_take pc32=%h required 00003100", pc32);
        end
        clear_inputs();
        tick();
        checks++;
        if (pc32 !== 32'h3104) begin
            errors++;
            $display("FAIL redir_next pc32=%h required 00003104", pc32);
        end
    endtask

    task automatic test_stall_buffer();
        clear_inputs();
        redirect = 1'b1; redirect_target = 32'h3020;
        tick();
        stall = 1'b1; redirect_target = 32'h3200;
        tick();
        redirect_target = 32'h3300;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (pc32 !== 32'h3020 || redirect_pending !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold pc32=%h pend=%b required 00003020 pend=1", pc32, redirect_pending);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc32 !== 32'h3300 || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL stall_release pc32=%h pend=%b required 00003300 pend=0", pc32, redirect_pending);
        end
    endtask

    task automatic test_exception();
        clear_inputs();
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h3400;
        exc_req = 1'b1; eret = 1'b1; epc = 32'h3058;
        tick();
        checks++;
        if (pc32 !== EXC_PC || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL exc_priority pc32=%h pend=%b required 00004180 pend=0", pc32, redirect_pending);
        end
        clear_inputs();
        tick();
        checks++;
        if (pc32 !== 32'h4184) begin
            errors++;
            $display("FAIL exc_next pc32=%h required 00004184", pc32);
        end
    endtask

    task automatic test_eret();
        clear_inputs();
        eret = 1'b1; epc = 32'h3058; stall = 1'b1;
        tick();
        checks++;
        if (pc32 !== 32'h3058) begin
            errors++;
            $display("FAIL eret_take pc32=%h required 00003058", pc32);
        end
        clear_inputs();
        tick();
        checks++;
        if (pc32 !== 32'h305C) begin
            errors++;
            $display("FAIL eret_next pc32=%h required 0000305c", pc32);
        end
    endtask

    task automatic test_reset_pending_wrap();
        clear_inputs();
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h3500;
        tick();
        redirect = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if (pc32 !== RST_PC || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending pc32=%h pend=%b required 00003000 pend=0", pc32, redirect_pending);
        end
        clear_inputs();
        tick();
        checks++;
        if (pc32 !== 32'h3004) begin
            errors++;
            $display("FAIL reset_discard pc32=%h required 00003004", pc32);
        end
        redirect = 1'b1; redirect_target = 32'hFFFFFFFC;
        tick();
        checks++;
        if (pc32 !== 32'hFFFFFFFC || pc4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_setup pc32=%h pc4=%h required fffffffc/00000000", pc32, pc4);
        end
        clear_inputs();
        tick();
        checks++;
        if (pc32 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_advance pc32=%h required 00000000", pc32);
        end
    endtask

    task automatic test_random();
        logic exp_pend;
        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 49) == 0);
            exc_req         = ($urandom_range(0, 19) == 0);
            eret            = ($urandom_range(0, 19) == 0);
            stall           = ($urandom_range(0, 2) == 0);
            redirect        = ($urandom_range(0, 3) == 0);
            redirect_target = $urandom;
            epc             = $urandom;
            tick();
            exp_pend = (m_pend.size() > 0);
            checks++;
            if (pc32 !== m_pc || pc4 !== m_pc + 32'd4 || redirect_pending !== exp_pend) begin
                errors++;
                $display("FAIL random[%0d] pc32=%h pc4=%h pend=%b required %h %h %b",
                         i, pc32, pc4, redirect_pending, m_pc, m_pc + 32'd4, exp_pend);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        m_pc = RST_PC;
        #1;
        test_reset();
        test_redirect();
        test_stall_buffer();
        test_exception();
        test_eret();
        test_reset_pending_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
